// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out shift register with valid/ready load port
//
// Purpose:
//   Accepts a WIDTH-bit word through a valid/ready handshake and emits it one
//   bit per clock edge on which enable is high. Words can be chained with no
//   idle gap by presenting the next word while the final bit is on the line.
//
// Parameters:
//   WIDTH     - word width in bits, legal range 2..32
//   MSB_FIRST - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_VAL  - line level whenever no word is active (and after reset)
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset
//   load_valid - load_data holds a word to send
//   load_data  - parallel word
//   load_ready - a word is accepted this cycle when load_valid is also high
//   enable     - shift strobe, one bit per clk edge while high
//   out        - current serial bit (IDLE_VAL when idle)
//   out_valid  - out carries a data bit
//   last       - out is the final bit of the current word
//   busy       - a word is in progress

module piso_shift_reg #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             enable,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam int             OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shreg_n;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic              shifting;

    assign shifting = (state == ST_SHIFT);

    // Every output below is a function of registered state only, except
    // load_ready, which must see enable so the next word can be accepted on
    // the same edge that retires the final bit.
    assign busy       = shifting;
    assign out_valid  = shifting;
    assign last       = shifting && (count == LAST_CNT);
    assign out        = shifting ? shreg[OUT_IDX] : IDLE_VAL;
    assign load_ready = (state == ST_IDLE) || (last && enable);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            shreg <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        count_n = count;
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    state_n = ST_SHIFT;
                    shreg_n = load_data;
                    count_n = '0;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    if (last) begin
                        if (load_valid) begin
                            // Chain straight into the next word.
                            shreg_n = load_data;
                            count_n = '0;
                        end else begin
                            state_n = ST_IDLE;
                            shreg_n = '0;
                            count_n = '0;
                        end
                    end else begin
                        // Zero fill from the far end so stale bits never
                        // reappear at the output.
                        shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        count_n = count + CW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                shreg_n = '0;
                count_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb/tb_piso_shift_reg.sv - scoreboard bench for piso_shift_reg (MSB-first/idle-0 and LSB-first/idle-1)

module tb_piso_shift_reg;

    logic       clk;
    logic       rst;
    logic       lv  [2];
    logic [7:0] ld  [2];
    logic       en  [2];
    logic       rdy [2];
    logic       o   [2];
    logic       ov  [2];
    logic       lst [2];
    logic       by  [2];

    int checks;
    int errors;
    int en_mode;
    int ecnt;
    bit track_busy;
    int busy_drops;

    // Each entry: {last, bit}
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_msb (
        .clk(clk), .reset(rst),
        .load_valid(lv[0]), .load_data(ld[0]), .load_ready(rdy[0]),
        .enable(en[0]), .out(o[0]), .out_valid(ov[0]), .last(lst[0]), .busy(by[0])
    );

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) u_lsb (
        .clk(clk), .reset(rst),
        .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rdy[1]),
        .enable(en[1]), .out(o[1]), .out_valid(ov[1]), .last(lst[1]), .busy(by[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_word(input int u, input logic [7:0] d);
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            e[0] = (u == 0) ? d[7-i] : d[i];
            e[1] = (i == 7);
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic mon(input int u, input string p, input logic mo, input logic mv,
                       input logic ml, input logic mb, input logic mr, input logic me,
                       input logic idle_lvl);
        logic [1:0] e;
        if (mv) begin
            if (qsize(u) == 0) begin
                chk({p, "unexpected_bit"}, 32'(1), 32'(0));
            end else begin
                e = (u == 0) ? q0[0] : q1[0];
                chk({p, "out"},   32'(mo), 32'(e[0]));
                chk({p, "last"},  32'(ml), 32'(e[1]));
                chk({p, "ready"}, 32'(mr), 32'(e[1] & me));
                chk({p, "busy"},  32'(mb), 32'(1));
                if (me) begin
                    if (u == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end else begin
            chk({p, "idle_out"},   32'(mo), 32'(idle_lvl));
            chk({p, "idle_busy"},  32'(mb), 32'(0));
            chk({p, "idle_last"},  32'(ml), 32'(0));
            chk({p, "idle_ready"}, 32'(mr), 32'(1));
        end
    endtask

    always @(negedge clk) begin
        mon(0, "u0_", o[0], ov[0], lst[0], by[0], rdy[0], en[0], 1'b0);
        mon(1, "u1_", o[1], ov[1], lst[1], by[1], rdy[1], en[1], 1'b1);
        if (track_busy && !by[0]) busy_drops++;
    end

    // One clock: inputs change at +1 after the edge, caller resumes at +2.
    task automatic step();
        logic e;
        @(posedge clk);
        #1;
        e = (en_mode == 0) ? 1'b1 : ((ecnt % 3) == 0);
        en[0] = e;
        en[1] = e;
        ecnt++;
        #1;
    endtask

    task automatic load_word(input int u, input logic [7:0] d, input bit keep);
        bit hs;
        int n;
        lv[u] = 1'b1;
        ld[u] = d;
        push_word(u, d);
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 60) begin
            hs = rdy[u];
            step();
            n++;
        end
        if (!hs) chk("handshake_timeout", 32'(0), 32'(1));
        if (!keep) lv[u] = 1'b0;
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while (qsize(u) != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_remaining", 32'(qsize(u)), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        en_mode    = 0;
        ecnt       = 0;
        track_busy = 1'b0;
        busy_drops = 0;
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0;
            ld[i] = 8'h00;
            en[i] = 1'b0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: monitor checks idle levels every cycle.
        repeat (5) step();

        // MSB-first word with continuous enable.
        load_word(0, 8'hA5, 1'b0);
        drain(0);
        repeat (3) step();

        // Enable pattern 1,0,0; data changes after handshake must not matter.
        en_mode = 1;
        ecnt    = 0;
        load_word(0, 8'hA5, 1'b0);
        ld[0] = 8'hFF;
        drain(0);
        en_mode = 0;
        repeat (3) step();

        // Back-to-back words with load_valid held.
        load_word(0, 8'hA5, 1'b1);
        track_busy = 1'b1;
        load_word(0, 8'h3C, 1'b0);
        drain(0);
        track_busy = 1'b0;
        chk("b2b_busy_drops", 32'(busy_drops), 32'(0));
        repeat (3) step();

        // Asynchronous reset mid-word.
        load_word(0, 8'hF0, 1'b0);
        repeat (3) step();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out",   32'(o[0]),   32'(0));
        chk("async_rst_busy",  32'(by[0]),  32'(0));
        chk("async_rst_ready", 32'(rdy[0]), 32'(1));
        q0.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        load_word(0, 8'h81, 1'b0);
        drain(0);
        repeat (3) step();

        // LSB-first, idle-high instance; mid-word load attempt is ignored.
        load_word(1, 8'h01, 1'b0);
        repeat (3) step();
        lv[1] = 1'b1;
        ld[1] = 8'hFF;
        step();
        lv[1] = 1'b0;
        drain(1);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
